gray_step_monitor: RTL and testbench
====================================

# gray_step_monitor

Downstream consumer of the registered Gray-code stream produced by the `binary_to_gray` → `register4` path. It accepts one Gray sample per valid cycle and decodes it to binary. It classifies each sample against the previous one as up-step, down-step, hold or illegal jump, and escalates repeated illegal jumps into a sticky fault state. It lets the lab bench check Gray-stream integrity in hardware rather than by eyeballing `$display` output.

## Interface
Parameters:
- `WIDTH`, 4: Gray/binary word width (2..8).
- `ERR_LIMIT`, 3: consecutive illegal jumps that trigger FAULT (1..15).

Ports:
- `clk`  in  1: clock, all state updates on rising edge.
- `rst`  in  1: reset, synchronous, active-high, highest priority.
- `clr`  in  1: synchronous soft clear. Returns to IDLE and zeroes counters. Priority below `rst`, above `in_valid`.
- `in_valid`  in  1: `gray_in` is sampled this edge.
- `gray_in`  in  WIDTH: Gray-coded sample.
- `bin_out`  out  WIDTH: registered binary decode of last accepted sample.
- `step_up`  out  1: one-cycle pulse, last sample was +1 (mod 2^WIDTH).
- `step_dn`  out  1: one-cycle pulse, last sample was −1 (mod 2^WIDTH).
- `jump_err`  out  1: one-cycle pulse, last sample was an illegal jump.
- `locked`  out  1: high in TRACK.
- `fault`  out  1: high in FAULT.
- `step_count`  out  8: saturating count of legal steps (up + down).
- `err_count`  out  8: saturating count of illegal jumps.

## Operation
- Decode: `b[WIDTH-1] = g[WIDTH-1]`; `b[i] = b[i+1] ^ g[i]`.
- Classification, with `d = cur_bin − prev_bin` mod 2^WIDTH:
  - d = 1 → up.
  - d = 2^WIDTH−1 → down.
  - d = 0 → hold: no pulse, no count change, consecutive-error counter unchanged.
  - anything else → jump.
- Wrap-around is legal: 1111→0000 is up, 0000→1111 is down (binary view).
- FSM states: IDLE, TRACK, FAULT.
  - IDLE: first accepted sample loads `prev_bin` and `bin_out`, emits no pulse, moves to TRACK.
  - TRACK, up/down: pulse `step_up`/`step_dn`, `step_count`++, consecutive-error counter ← 0.
  - TRACK, jump: pulse `jump_err`, `err_count`++, consecutive-error counter++. When the counter reaches ERR_LIMIT, move to FAULT.
  - FAULT: sticky. Samples still decode to `bin_out` and update `prev_bin`, but produce no pulses and no count changes. Exit only via `rst` or `clr` to IDLE.
- Every accepted sample updates `prev_bin`, jumps included. The next comparison is always against the most recent sample.
- Counters saturate at 255; no wrap.
- `in_valid` low: state, `prev_bin`, `bin_out` and counters hold; all pulses low.

## Timing
- Latency is 1 cycle. A sample accepted at edge N appears on `bin_out`, and its pulse is asserted, during cycle N→N+1.
- Pulses last exactly one cycle per accepted sample. Back-to-back valid samples give back-to-back pulses.
- Reset values: `bin_out` = 0, all pulses = 0, `locked` = 0, `fault` = 0, both counters = 0, consecutive-error counter = 0, state = IDLE.
- `rst` or `clr` asserted together with `in_valid`: the sample is discarded and the block enters IDLE.
- Reset mid-stream: the next accepted sample is treated as a first sample, with no pulse.
- Transition into FAULT: `jump_err` pulses and `fault` rises in the same cycle; `locked` falls in that cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `gray_pkg`:
  - state enum `gs_state_t` {IDLE, TRACK, FAULT};
  - counter width constant `GS_CNT_W = 8`;
  - saturation max constant `GS_CNT_MAX = 8'hFF`.
- One sub-module: `gray2bin_n`, a parameterised combinational WIDTH-bit decoder. It generalises the existing 4-bit `gray_to_binary` and is instantiated once.
- Classification logic and the FSM live in the top module.

## Test plan
- Up sweep: after reset, feed Gray of 0..15 then 0 (17 valid cycles) → one sample with no pulse, then 16 `step_up` pulses, `step_count` = 16, `err_count` = 0, `locked` = 1, `bin_out` = 0 at end.
- Down sweep: feed Gray of 5,4,3,2,1,0,15 → 6 `step_dn` pulses, wrap 0→15 counted as down, `step_count` = 6.
- Isolated jump: feed Gray 2,3,7,8 → 3→7 gives `jump_err`, `err_count` = 1; 7→8 gives `step_up` and resets the consecutive count; `locked` stays 1.
- Fault escalation (ERR_LIMIT = 3): feed Gray 0,5,10,15 → 3 `jump_err` pulses, `fault` = 1 and `locked` = 0 after the 4th sample. Further samples 15→0 produce no pulses and no count change. `clr` returns to IDLE with both counters at 0.
- Holds and gaps: feed Gray 4,4,(in_valid low 3 cycles),5 → hold produces nothing, the gap changes nothing, then one `step_up`; `step_count` = 1.
- Reset mid-operation: after samples 0,1,2, assert `rst` together with `in_valid` carrying Gray 9 → all outputs at reset values and the sample is dropped. The next sample (Gray 7) produces no pulse; `bin_out` = 7.

Source files
------------

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared types and constants for the Gray-stream step monitor
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    FAULT
  } gs_state_t;

  localparam int GS_CNT_W = 8;
  localparam logic [GS_CNT_W-1:0] GS_CNT_MAX = 8'hFF;

  function automatic logic [GS_CNT_W-1:0] gs_sat_inc(input logic [GS_CNT_W-1:0] v);
    return (v == GS_CNT_MAX) ? v : v + GS_CNT_W'(1);
  endfunction

endpackage

// File: rtl/gray2bin_n.sv
// rtl/gray2bin_n.sv - combinational WIDTH-bit Gray to binary decoder
module gray2bin_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above its position.
  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_step_monitor.sv
// rtl/gray_step_monitor.sv - decodes a Gray sample stream, classifies each step
// and escalates repeated illegal jumps into a sticky fault state
module gray_step_monitor
  import gray_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ERR_LIMIT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    gray_in,
  output logic [WIDTH-1:0]    bin_out,
  output logic                step_up,
  output logic                step_dn,
  output logic                jump_err,
  output logic                locked,
  output logic                fault,
  output logic [GS_CNT_W-1:0] step_count,
  output logic [GS_CNT_W-1:0] err_count
);

  localparam logic [3:0]       ERR_LIM = 4'(ERR_LIMIT);
  localparam logic [WIDTH-1:0] D_UP    = WIDTH'(1);
  localparam logic [WIDTH-1:0] D_DN    = '1;

  gs_state_t           state_q, state_d;
  logic [WIDTH-1:0]    prev_bin_q, prev_bin_d;
  logic [WIDTH-1:0]    bin_out_q, bin_out_d;
  logic                step_up_q, step_up_d;
  logic                step_dn_q, step_dn_d;
  logic                jump_err_q, jump_err_d;
  logic                locked_q, locked_d;
  logic                fault_q, fault_d;
  logic [GS_CNT_W-1:0] step_count_q, step_count_d;
  logic [GS_CNT_W-1:0] err_count_q, err_count_d;
  logic [3:0]          consec_q, consec_d;

  logic [WIDTH-1:0]    cur_bin;
  logic [WIDTH-1:0]    diff;

  gray2bin_n #(.WIDTH(WIDTH)) u_dec (
    .gray (gray_in),
    .bin  (cur_bin)
  );

  assign diff = cur_bin - prev_bin_q;

  always_comb begin
    state_d      = state_q;
    prev_bin_d   = prev_bin_q;
    bin_out_d    = bin_out_q;
    step_up_d    = 1'b0;
    step_dn_d    = 1'b0;
    jump_err_d   = 1'b0;
    locked_d     = locked_q;
    fault_d      = fault_q;
    step_count_d = step_count_q;
    err_count_d  = err_count_q;
    consec_d     = consec_q;

    if (clr) begin
      // Soft clear drops any concurrent sample and restarts tracking.
      state_d      = IDLE;
      locked_d     = 1'b0;
      fault_d      = 1'b0;
      step_count_d = '0;
      err_count_d  = '0;
      consec_d     = '0;
    end else if (in_valid) begin
      prev_bin_d = cur_bin;
      bin_out_d  = cur_bin;
      unique case (state_q)
        IDLE: begin
          state_d  = TRACK;
          locked_d = 1'b1;
        end
        TRACK: begin
          if (diff == D_UP || diff == D_DN) begin
            step_up_d    = (diff == D_UP);
            step_dn_d    = (diff == D_DN);
            step_count_d = gs_sat_inc(step_count_q);
            consec_d     = '0;
          end else if (diff != '0) begin
            jump_err_d  = 1'b1;
            err_count_d = gs_sat_inc(err_count_q);
            consec_d    = consec_q + 4'd1;
            if (consec_d >= ERR_LIM) begin
              state_d  = FAULT;
              locked_d = 1'b0;
              fault_d  = 1'b1;
            end
          end
        end
        FAULT: begin
          // Sticky: keep decoding, but no pulses or count changes.
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      prev_bin_q   <= '0;
      bin_out_q    <= '0;
      step_up_q    <= 1'b0;
      step_dn_q    <= 1'b0;
      jump_err_q   <= 1'b0;
      locked_q     <= 1'b0;
      fault_q      <= 1'b0;
      step_count_q <= '0;
      err_count_q  <= '0;
      consec_q     <= '0;
    end else begin
      state_q      <= state_d;
      prev_bin_q   <= prev_bin_d;
      bin_out_q    <= bin_out_d;
      step_up_q    <= step_up_d;
      step_dn_q    <= step_dn_d;
      jump_err_q   <= jump_err_d;
      locked_q     <= locked_d;
      fault_q      <= fault_d;
      step_count_q <= step_count_d;
      err_count_q  <= err_count_d;
      consec_q     <= consec_d;
    end
  end

  assign bin_out    = bin_out_q;
  assign step_up    = step_up_q;
  assign step_dn    = step_dn_q;
  assign jump_err   = jump_err_q;
  assign locked     = locked_q;
  assign fault      = fault_q;
  assign step_count = step_count_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_gray_step_monitor.sv
// tb/tb_gray_step_monitor.sv - scoreboard bench for gray_step_monitor
module tb_gray_step_monitor;

  localparam int W   = 4;
  localparam int LIM = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clr = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] gray_in = '0;
  logic [W-1:0] bin_out;
  logic         step_up, step_dn, jump_err, locked, fault;
  logic [7:0]   step_count, err_count;

  gray_step_monitor #(.WIDTH(W), .ERR_LIMIT(LIM)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_valid   (in_valid),
    .gray_in    (gray_in),
    .bin_out    (bin_out),
    .step_up    (step_up),
    .step_dn    (step_dn),
    .jump_err   (jump_err),
    .locked     (locked),
    .fault      (fault),
    .step_count (step_count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] bin;
    logic         up;
    logic         dn;
    logic         jerr;
    logic         lck;
    logic         flt;
    logic [7:0]   steps;
    logic [7:0]   errs;
  } obs_t;

  obs_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  int           m_state = 0;  // 0 idle, 1 track, 2 fault
  logic [W-1:0] m_prev = '0;
  logic [W-1:0] m_bin = '0;
  int           m_steps = 0;
  int           m_errs = 0;
  int           m_consec = 0;

  function automatic logic [W-1:0] to_gray(input int n);
    logic [W-1:0] b;
    b = W'(n);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic obs_t observe();
    return {bin_out, step_up, step_dn, jump_err, locked, fault, step_count, err_count};
  endfunction

  // Drives one cycle of stimulus, advances the reference model and queues its prediction.
  task automatic drive(input logic v, input int n, input logic r, input logic c);
    logic [W-1:0] b, d;
    logic         up, dn, je;
    obs_t         e;
    up = 1'b0; dn = 1'b0; je = 1'b0;
    rst = r; clr = c; in_valid = v; gray_in = to_gray(n);
    if (r) begin
      m_state = 0; m_prev = '0; m_bin = '0; m_steps = 0; m_errs = 0; m_consec = 0;
    end else if (c) begin
      m_state = 0; m_steps = 0; m_errs = 0; m_consec = 0;
    end else if (v) begin
      b = g2b(to_gray(n));
      if (m_state == 0) begin
        m_state = 1;
      end else if (m_state == 1) begin
        d = b - m_prev;
        if (d == W'(1)) begin
          up = 1'b1; m_consec = 0;
          if (m_steps < 255) m_steps++;
        end else if (d == {W{1'b1}}) begin
          dn = 1'b1; m_consec = 0;
          if (m_steps < 255) m_steps++;
        end else if (d != '0) begin
          je = 1'b1; m_consec++;
          if (m_errs < 255) m_errs++;
          if (m_consec >= LIM) m_state = 2;
        end
      end
      m_prev = b;
      m_bin  = b;
    end
    e = {m_bin, up, dn, je, (m_state == 1), (m_state == 2), 8'(m_steps), 8'(m_errs)};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 6, 1'b1, 1'b0);
      got = observe(); exp = sb.pop_front();
      n_checks++;
      if (got !== '0 || exp !== '0) begin
        n_fails++; $display("FAIL reset_state[%0d] got=%h required=0", i, got);
      end
    end
  endtask

  task automatic test_up_sweep();
    obs_t got, exp;
    int ups;
    ups = 0;
    drive(1'b0, 0, 1'b1, 1'b0); void'(sb.pop_front());
    for (int i = 0; i <= 16; i++) begin
      drive(1'b1, i % 16, 1'b0, 1'b0);
      got = observe(); exp = sb.pop_front();
      ups += int'(got.up);
      n_checks++;
      if (got !== exp) begin
        n_fails++; $display("FAIL up_sweep[%0d] got=%h required=%h", i, got, exp);
      end
    end
    n_checks++;
    if (ups != 16 || step_count !== 8'd16 || err_count !== 8'd0 || locked !== 1'b1 || bin_out !== 4'd0) begin
      n_fails++;
      $display("FAIL up_sweep_totals got ups=%0d steps=%0d errs=%0d locked=%b bin=%0d required 16/16/0/1/0",
               ups, step_count, err_count, locked, bin_out);
    end
  endtask

  task automatic test_down_sweep();
    obs_t got, exp;
    int dns;
    int vals[7] = '{5, 4, 3, 2, 1, 0, 15};
    dns = 0;
    drive(1'b0, 0, 1'b1, 1'b0); void'(sb.pop_front());
    foreach (vals[i]) begin
      drive(1'b1, vals[i], 1'b0, 1'b0);
      got = observe(); exp = sb.pop_front();
      dns += int'(got.dn);
      n_checks++;
      if (got !== exp) begin
        n_fails++; $display("FAIL down_sweep[%0d] got=%h required=%h", i, got, exp);
      end
    end
    n_checks++;
    if (dns != 6 || step_count !== 8'd6 || bin_out !== 4'd15) begin
      n_fails++;
      $display("FAIL down_sweep_totals got dns=%0d steps=%0d bin=%0d required 6/6/15", dns, step_count, bin_out);
    end
  endtask

  task automatic test_isolated_jump();
    obs_t got, exp;
    int vals[4] = '{2, 3, 7, 8};
    drive(1'b0, 0, 1'b1, 1'b0); void'(sb.pop_front());
    foreach (vals[i]) begin
      drive(1'b1, vals[i], 1'b0, 1'b0);
      got = observe(); exp = sb.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fails++; $display("FAIL isolated_jump[%0d] got=%h required=%h", i, got, exp);
      end
      if (i == 2) begin
        n_checks++;
        if (jump_err !== 1'b1 || err_count !== 8'd1) begin
          n_fails++; $display("FAIL jump_pulse got jerr=%b errs=%0d required 1/1", jump_err, err_count);
        end
      end
    end
    n_checks++;
    if (step_up !== 1'b1 || locked !== 1'b1 || fault !== 1'b0) begin
      n_fails++; $display("FAIL jump_recover got up=%b locked=%b fault=%b required 1/1/0", step_up, locked, fault);
    end
  endtask

  task automatic test_fault();
    obs_t got, exp;
    int jerrs;
    int vals[6] = '{0, 5, 10, 15, 15, 0};
    jerrs = 0;
    drive(1'b0, 0, 1'b1, 1'b0); void'(sb.pop_front());
    foreach (vals[i]) begin
      drive(1'b1, vals[i], 1'b0, 1'b0);
      got = observe(); exp = sb.pop_front();
      jerrs += int'(got.jerr);
      n_checks++;
      if (got !== exp) begin
        n_fails++; $display("FAIL fault_seq[%0d] got=%h required=%h", i, got, exp);
      end
      if (i == 3) begin
        n_checks++;
        if (fault !== 1'b1 || locked !== 1'b0 || jump_err !== 1'b1) begin
          n_fails++; $display("FAIL fault_entry got fault=%b locked=%b jerr=%b required 1/0/1", fault, locked, jump_err);
        end
      end
    end
    n_checks++;
    if (jerrs != 3 || err_count !== 8'd3 || step_count !== 8'd0 || bin_out !== 4'd0 || fault !== 1'b1) begin
      n_fails++;
      $display("FAIL fault_sticky got jerrs=%0d errs=%0d steps=%0d bin=%0d fault=%b required 3/3/0/0/1",
               jerrs, err_count, step_count, bin_out, fault);
    end
    drive(1'b1, 9, 1'b0, 1'b1);
    got = observe(); exp = sb.pop_front();
    n_checks++;
    if (got !== exp || err_count !== 8'd0 || step_count !== 8'd0 || fault !== 1'b0 || locked !== 1'b0) begin
      n_fails++; $display("FAIL clr_idle got=%h required=%h", got, exp);
    end
    drive(1'b1, 3, 1'b0, 1'b0);
    got = observe(); exp = sb.pop_front();
    n_checks++;
    if (got !== exp || locked !== 1'b1 || step_up !== 1'b0 || jump_err !== 1'b0) begin
      n_fails++; $display("FAIL clr_first_sample got=%h required=%h", got, exp);
    end
  endtask

  task automatic test_hold_gap();
    obs_t got, exp;
    logic vld[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int   vals[6] = '{4, 4, 12, 0, 9, 5};
    drive(1'b0, 0, 1'b1, 1'b0); void'(sb.pop_front());
    foreach (vals[i]) begin
      drive(vld[i], vals[i], 1'b0, 1'b0);
      got = observe(); exp = sb.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fails++; $display("FAIL hold_gap[%0d] got=%h required=%h", i, got, exp);
      end
    end
    n_checks++;
    if (step_count !== 8'd1 || step_up !== 1'b1 || bin_out !== 4'd5 || err_count !== 8'd0) begin
      n_fails++; $display("FAIL hold_gap_totals got steps=%0d up=%b bin=%0d required 1/1/5", step_count, step_up, bin_out);
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, exp;
    drive(1'b0, 0, 1'b1, 1'b0); void'(sb.pop_front());
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i, 1'b0, 1'b0);
      got = observe(); exp = sb.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fails++; $display("FAIL reset_mid_pre[%0d] got=%h required=%h", i, got, exp);
      end
    end
    drive(1'b1, 9, 1'b1, 1'b0);
    got = observe(); void'(sb.pop_front());
    n_checks++;
    if (got !== '0) begin
      n_fails++; $display("FAIL reset_mid_drop got=%h required=0", got);
    end
    drive(1'b1, 7, 1'b0, 1'b0);
    got = observe(); exp = sb.pop_front();
    n_checks++;
    if (got !== exp || bin_out !== 4'd7 || step_up !== 1'b0 || step_dn !== 1'b0 || jump_err !== 1'b0) begin
      n_fails++; $display("FAIL reset_mid_first got=%h required=%h", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, exp;
    int   cur, kind;
    logic v, c;
    cur = 0;
    drive(1'b0, 0, 1'b1, 1'b0); void'(sb.pop_front());
    for (int i = 0; i < 400; i++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 4)      cur = (cur + 1) % 16;
      else if (kind < 7) cur = (cur + 15) % 16;
      else if (kind < 8) cur = cur;
      else               cur = int'($urandom_range(0, 15));
      v = ($urandom_range(0, 4) != 0);
      c = ($urandom_range(0, 39) == 0);
      drive(v, cur, 1'b0, c);
      got = observe(); exp = sb.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fails++; $display("FAIL back_to_back[%0d] got=%h required=%h", i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_sweep();
    test_down_sweep();
    test_isolated_jump();
    test_fault();
    test_hold_gap();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
